axi_byte_responder: RTL

// AXI4-Lite subordinate on the 64-bit data path; bridges strobed 64-bit word accesses to a byte-wide peripheral port.

---
 rtl/axi_byte_responder_if.sv | 45 ++++
 rtl/axi_byte_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/axi_byte_responder_if.sv
// Bus bundle for axi_byte_responder: the AXI4-Lite subordinate channels
// (64-bit data path) and the byte-wide peripheral port.
//   slave  : the responder's view (drives AXI ready/response and byte_* request)
//   master : the environment's view (interconnect + byte peripheral)
interface axi_byte_responder_if #(
   parameter int ADDR_WIDTH = 8
) ();
   logic [31:0]           s_awaddr;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [63:0]           s_wdata;
   logic [7:0]            s_wstrb;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [1:0]            s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [31:0]           s_araddr;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [63:0]           s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rvalid;
   logic                  s_rready;
   logic [ADDR_WIDTH-1:0] byte_addr;
   logic [7:0]            byte_wdata;
   logic                  byte_we;
   logic                  byte_req;
   logic                  byte_ack;
   logic [7:0]            byte_rdata;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready, byte_ack, byte_rdata,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
             s_rdata, s_rresp, s_rvalid, byte_addr, byte_wdata, byte_we, byte_req
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready, byte_ack, byte_rdata,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
             s_rdata, s_rresp, s_rvalid, byte_addr, byte_wdata, byte_we, byte_req
   );
endinterface

// File: rtl/axi_byte_responder.sv
// AXI4-Lite subordinate that bridges single-byte strobed 64-bit writes and
// byte reads onto a byte-wide request/acknowledge peripheral port.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset (aborts any access in flight)
//   bus    - axi_byte_responder_if.slave: AW/W/B/AR/R channels plus
//            byte_addr/byte_wdata/byte_we/byte_req (out), byte_ack/byte_rdata (in)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | accepting AW/W (independently) or AR when no write pending
// S_WR_ACC  | byte write request on the peripheral port, waiting for ack
// S_WR_RESP | B response presented, waiting for bready
// S_RD_ACC  | byte read request on the peripheral port, waiting for ack
// S_RD_RESP | R response presented, waiting for rready
module axi_byte_responder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   axi_byte_responder_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ACC, S_WR_RESP, S_RD_ACC, S_RD_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_aw_held;
   logic [ADDR_WIDTH-1:3] r_aw_addr;
   logic                  r_w_held;
   logic [63:0]           r_wdata;
   logic [7:0]            r_wstrb;
   logic [1:0]            r_bresp;
   logic [63:0]           r_rdata;
   logic [ADDR_WIDTH-1:0] r_byte_addr;
   logic [7:0]            r_byte_wdata;
   logic                  r_byte_we;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic [ADDR_WIDTH-1:3] w_aw_addr;
   logic [63:0]           w_wdata;
   logic [7:0]            w_wstrb;
   logic                  w_wr_go;
   logic                  w_strb_onehot;
   logic [2:0]            w_lane;
   logic [7:0]            w_lane_byte;
   logic                  w_unused_addr_bits;

   // Address bits outside the peripheral window alias by design.
   assign w_unused_addr_bits = ^{bus.s_awaddr[31:ADDR_WIDTH], bus.s_awaddr[2:0],
                                 bus.s_araddr[31:ADDR_WIDTH]};

   assign w_aw_hs = bus.s_awvalid & bus.s_awready;
   assign w_w_hs  = bus.s_wvalid  & bus.s_wready;
   assign w_ar_hs = bus.s_arvalid & bus.s_arready;

   // Bypass the holding registers so a write can be decoded in the same
   // cycle as its last handshake; this keeps the response two cycles out.
   assign w_aw_addr = r_aw_held ? r_aw_addr : bus.s_awaddr[ADDR_WIDTH-1:3];
   assign w_wdata   = r_w_held  ? r_wdata   : bus.s_wdata;
   assign w_wstrb   = r_w_held  ? r_wstrb   : bus.s_wstrb;
   assign w_wr_go   = (r_state == S_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

   assign w_strb_onehot = (w_wstrb != 8'd0) && ((w_wstrb & (w_wstrb - 8'd1)) == 8'd0);

   always_comb begin
      w_lane = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (w_wstrb[i]) w_lane = 3'(i);
      end
   end

   assign w_lane_byte = w_wdata[{w_lane, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_aw_held    <= 1'b0;
         r_aw_addr    <= '0;
         r_w_held     <= 1'b0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_bresp      <= RESP_OKAY;
         r_rdata      <= '0;
         r_byte_addr  <= '0;
         r_byte_wdata <= '0;
         r_byte_we    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_addr <= bus.s_awaddr[ADDR_WIDTH-1:3];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= bus.s_wdata;
            r_wstrb  <= bus.s_wstrb;
         end
         if (r_state == S_WR_RESP && bus.s_bready) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (w_wr_go) begin
            if (w_strb_onehot) begin
               r_byte_addr  <= {w_aw_addr, w_lane};
               r_byte_wdata <= w_lane_byte;
               r_byte_we    <= 1'b1;
               r_bresp      <= RESP_OKAY;
            end else begin
               r_bresp <= (w_wstrb == 8'd0) ? RESP_OKAY : RESP_SLVERR;
            end
         end
         if (w_ar_hs) begin
            r_byte_addr <= bus.s_araddr[ADDR_WIDTH-1:0];
            r_byte_we   <= 1'b0;
         end
         if (r_state == S_RD_ACC && bus.byte_ack) begin
            r_rdata <= {8{bus.byte_rdata}};
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_wr_go)      w_state_nxt = w_strb_onehot ? S_WR_ACC : S_WR_RESP;
            else if (w_ar_hs) w_state_nxt = S_RD_ACC;
         end
         S_WR_ACC:  if (bus.byte_ack) w_state_nxt = S_WR_RESP;
         S_WR_RESP: if (bus.s_bready) w_state_nxt = S_IDLE;
         S_RD_ACC:  if (bus.byte_ack) w_state_nxt = S_RD_RESP;
         S_RD_RESP: if (bus.s_rready) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.s_awready  = (r_state == S_IDLE) && !r_aw_held;
      bus.s_wready   = (r_state == S_IDLE) && !r_w_held;
      // A pending or offered write blocks reads, so writes win ties.
      bus.s_arready  = (r_state == S_IDLE) && !r_aw_held && !r_w_held
                       && !bus.s_awvalid && !bus.s_wvalid;
      bus.s_bvalid   = (r_state == S_WR_RESP);
      bus.s_bresp    = r_bresp;
      bus.s_rvalid   = (r_state == S_RD_RESP);
      bus.s_rdata    = r_rdata;
      bus.s_rresp    = RESP_OKAY;
      bus.byte_req   = (r_state == S_WR_ACC) || (r_state == S_RD_ACC);
      bus.byte_addr  = r_byte_addr;
      bus.byte_wdata = r_byte_wdata;
      bus.byte_we    = r_byte_we;
   end

endmodule
